// File: rtl/lfsr_checker.sv
// lfsr_checker
//
// Receive-side checker for the XNOR LFSR pattern driven onto the status LEDs.
// It seeds a predictor from the first usable word, verifies a run of correct
// predictions before declaring lock, and then counts mismatches. While locked,
// the predictor keeps advancing on every word, so one corrupted word costs
// exactly one error. The checker also flags the all-ones lockup word and a
// pattern source that has stopped sending.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     one-cycle strobe: in_data holds a new pattern step
//   in_data      received pattern word
//   clr          synchronous clear of error_count, lockup and timeout
//   locked       checker is in the LOCKED state
//   error_pulse  one-cycle pulse for each mismatch while locked
//   error_count  saturating mismatch count
//   lockup       sticky: an all-ones word was received
//   timeout      sticky: the in_valid gap reached MAX_GAP cycles
module lfsr_checker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned TAP_HI      = 3,
    parameter int unsigned TAP_LO      = 2,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned LOSS_COUNT  = 3,
    parameter int unsigned ERR_WIDTH   = 16,
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned MAX_GAP     = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 clr,
    output logic                 locked,
    output logic                 error_pulse,
    output logic [ERR_WIDTH-1:0] error_count,
    output logic                 lockup,
    output logic                 timeout
);

    localparam logic [1:0] ST_SEEK   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned LW = $clog2(LOSS_COUNT + 1);

    localparam logic [MW-1:0]          LOCK_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [LW-1:0]          LOSS_LAST = LW'(LOSS_COUNT - 1);
    localparam logic [COUNT_WIDTH-1:0] GAP_LAST  = COUNT_WIDTH'(MAX_GAP - 1);

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] w);
        return {w[WIDTH-2:0], ~(w[TAP_HI] ^ w[TAP_LO])};
    endfunction

    logic [1:0]             state_q,       state_d;
    logic [WIDTH-1:0]       pred_q,        pred_d;
    logic [MW-1:0]          match_cnt_q,   match_cnt_d;
    logic [LW-1:0]          miss_run_q,    miss_run_d;
    logic [COUNT_WIDTH-1:0] gap_q,         gap_d;
    logic                   error_pulse_q, error_pulse_d;
    logic [ERR_WIDTH-1:0]   error_count_q, error_count_d;
    logic                   lockup_q,      lockup_d;
    logic                   timeout_q,     timeout_d;

    logic all_ones;
    logic match;

    assign all_ones = &in_data;
    assign match    = (in_data == pred_q);

    always_comb begin
        state_d       = state_q;
        pred_d        = pred_q;
        match_cnt_d   = match_cnt_q;
        miss_run_d    = miss_run_q;
        gap_d         = gap_q;
        error_pulse_d = 1'b0;
        // clr is applied first so a coinciding event still lands on top of it.
        error_count_d = clr ? '0   : error_count_q;
        lockup_d      = clr ? 1'b0 : lockup_q;
        timeout_d     = clr ? 1'b0 : timeout_q;

        if (in_valid) begin
            gap_d = '0;
            if (all_ones) begin
                lockup_d = 1'b1;
            end
            case (state_q)
                ST_SEEK: begin
                    if (!all_ones) begin
                        pred_d      = lfsr_next(in_data);
                        match_cnt_d = '0;
                        state_d     = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (all_ones) begin
                        state_d = ST_SEEK;
                    end else if (match) begin
                        pred_d      = lfsr_next(pred_q);
                        match_cnt_d = match_cnt_q + MW'(1);
                        if (match_cnt_q == LOCK_LAST) begin
                            state_d    = ST_LOCKED;
                            miss_run_d = '0;
                        end
                    end else begin
                        // Reseed from the word just seen; no error while not locked.
                        pred_d      = lfsr_next(in_data);
                        match_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // Free-running predictor: a corrupted word does not derail it.
                    pred_d = lfsr_next(pred_q);
                    if (match) begin
                        miss_run_d = '0;
                    end else begin
                        error_pulse_d = 1'b1;
                        if (!(&error_count_d)) begin
                            error_count_d = error_count_d + ERR_WIDTH'(1);
                        end
                        miss_run_d = miss_run_q + LW'(1);
                        if (miss_run_q == LOSS_LAST) begin
                            state_d = ST_SEEK;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEEK;
                end
            endcase
        end else if (state_q == ST_SEEK) begin
            gap_d = '0;
        end else if (gap_q == GAP_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_SEEK;
            gap_d     = '0;
        end else begin
            gap_d = gap_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_SEEK;
            pred_q        <= '0;
            match_cnt_q   <= '0;
            miss_run_q    <= '0;
            gap_q         <= '0;
            error_pulse_q <= 1'b0;
            error_count_q <= '0;
            lockup_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pred_q        <= pred_d;
            match_cnt_q   <= match_cnt_d;
            miss_run_q    <= miss_run_d;
            gap_q         <= gap_d;
            error_pulse_q <= error_pulse_d;
            error_count_q <= error_count_d;
            lockup_q      <= lockup_d;
            timeout_q     <= timeout_d;
        end
    end

    assign locked      = (state_q == ST_LOCKED);
    assign error_pulse = error_pulse_q;
    assign error_count = error_count_q;
    assign lockup      = lockup_q;
    assign timeout     = timeout_q;

endmodule
